// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side controller.
package async_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_FIFO_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_obuf.sv
// Two-entry push/pop buffer holding words captured from the FIFO read port.
module fifo_rd_obuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;

endmodule

// File: rtl/async_fifo_reader.sv
// Read-domain controller: fetches from the async FIFO without underflow and
// presents the words as a valid/ready stream with a burst-end marker.
module async_fifo_reader
  import async_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 res_n,
  input  logic                 en,
  input  logic                 empty,
  input  logic                 underflow,
  input  logic [WIDTH-1:0]     rdata,
  output logic                 rd_en,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 err,
  output rd_state_e            dbg_state
);

  // Stream handshake: a beat transfers on every rd_clk edge where
  // m_valid and m_ready are both 1; m_data/m_last hold while m_valid && !m_ready.

  localparam int BIDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BURST_LEN - 1);

  rd_state_e            state_q, state_d;
  logic                 pend_q, pend_d;
  logic [BIDX_W-1:0]    bidx_q, bidx_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                 err_q, err_d;

  logic [1:0]           occ;
  logic                 pop;
  logic [2:0]           fill;

  fifo_rd_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk       (rd_clk),
    .rst_n     (res_n),
    .push      (pend_q),
    .push_data (rdata),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // Words already owed to the buffer after this edge; a new read must fit.
  assign fill  = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
  assign rd_en = (state_q == ST_RUN) & ~empty & (fill < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en) begin
          state_d = ST_RUN;
        end else if ((occ == 2'd0) && !pend_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_d     = rd_en;
    bidx_d     = bidx_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q | underflow;
    if (pop) begin
      bidx_d     = (bidx_q == BIDX_LAST) ? '0 : bidx_q + 1'b1;
      word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge rd_clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      bidx_q     <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      bidx_q     <= bidx_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  assign m_last    = m_valid & (bidx_q == BIDX_LAST);
  assign busy      = (state_q != ST_IDLE);
  assign word_cnt  = word_cnt_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
